// File: rtl/train_scheduler.sv
// train_scheduler: owns the datapoint RAM after loading and sequences weight/datapoint reads over NUM_EPOCHS passes.
module train_scheduler #(
  parameter int ADDR_WIDTH   = 3,
  parameter int NUM_DP       = 6,
  parameter int NUM_FEATURES = 6,
  parameter int DATA_WIDTH   = 16*(NUM_FEATURES+1),
  parameter int NUM_EPOCHS   = 4,
  parameter int EPOCH_WIDTH  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_we_i,
  input  logic [ADDR_WIDTH-1:0]  load_addr_i,
  input  logic [DATA_WIDTH-1:0]  load_data_i,
  input  logic                   load_done_i,
  output logic                   ram_en_o,
  output logic                   ram_we_o,
  output logic [ADDR_WIDTH-1:0]  ram_addr_o,
  output logic [DATA_WIDTH-1:0]  ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]  ram_rdata_i,
  output logic                   wt_valid_o,
  output logic                   dp_valid_o,
  output logic [DATA_WIDTH-1:0]  dp_data_o,
  input  logic                   dp_ready_i,
  input  logic                   upd_done_i,
  input  logic                   wb_valid_i,
  input  logic [DATA_WIDTH-1:0]  wb_data_i,
  output logic [EPOCH_WIDTH-1:0] epoch_o,
  output logic                   busy_o,
  output logic                   train_done_o
);
  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] RD_W     = 4'd1;
  localparam logic [3:0] CAP_W    = 4'd2;
  localparam logic [3:0] WT       = 4'd3;
  localparam logic [3:0] RD_DP    = 4'd4;
  localparam logic [3:0] CAP_DP   = 4'd5;
  localparam logic [3:0] PRESENT  = 4'd6;
  localparam logic [3:0] WAIT_UPD = 4'd7;
  localparam logic [3:0] NEXT     = 4'd8;
  localparam logic [3:0] WB       = 4'd9;
  localparam logic [3:0] DONE     = 4'd10;
  logic [3:0]             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  idx_q, idx_d;
  logic [EPOCH_WIDTH-1:0] epoch_q, epoch_d;
  logic [DATA_WIDTH-1:0]  dp_data_q, dp_data_d;
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    epoch_d     = epoch_q;
    dp_data_d   = dp_data_q;
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    case (state_q)
      IDLE: begin
        // loader owns the RAM port until load_done; a same-cycle write still lands
        ram_en_o    = 1'b1;
        ram_we_o    = load_we_i & ~rst_i;
        ram_addr_o  = load_addr_i;
        ram_wdata_o = load_data_i;
        if (load_done_i) state_d = (NUM_EPOCHS == 0) ? DONE : RD_W;
      end
      RD_W: begin
        ram_en_o = 1'b1;
        state_d  = CAP_W;
      end
      CAP_W: begin
        dp_data_d = ram_rdata_i;
        state_d   = WT;
      end
      WT: if (dp_ready_i) begin
        idx_d   = ADDR_WIDTH'(1);
        state_d = RD_DP;
      end
      RD_DP: begin
        ram_en_o   = 1'b1;
        ram_addr_o = idx_q;
        state_d    = CAP_DP;
      end
      CAP_DP: begin
        dp_data_d = ram_rdata_i;
        state_d   = PRESENT;
      end
      PRESENT:  if (dp_ready_i) state_d = upd_done_i ? NEXT : WAIT_UPD;
      WAIT_UPD: if (upd_done_i) state_d = NEXT;
      NEXT: begin
        idx_d   = (idx_q == ADDR_WIDTH'(NUM_DP)) ? idx_q : idx_q + 1'b1;
        state_d = (idx_q == ADDR_WIDTH'(NUM_DP)) ? WB : RD_DP;
      end
      WB: if (wb_valid_i) begin
        ram_en_o    = 1'b1;
        ram_we_o    = 1'b1;
        ram_wdata_o = wb_data_i;
        epoch_d     = epoch_q + 1'b1;
        state_d     = (epoch_d == EPOCH_WIDTH'(NUM_EPOCHS)) ? DONE : RD_W;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      epoch_q   <= '0;
      dp_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      epoch_q   <= epoch_d;
      dp_data_q <= dp_data_d;
    end
  end
  assign wt_valid_o   = state_q == WT;
  assign dp_valid_o   = state_q == PRESENT;
  assign dp_data_o    = dp_data_q;
  assign epoch_o      = epoch_q;
  assign busy_o       = (state_q != IDLE) && (state_q != DONE);
  assign train_done_o = state_q == DONE;
endmodule

// File: tb/tb_train_scheduler.sv
// tb_train_scheduler: directed scoreboard bench; a 4-epoch instance for handshake scenarios, a 1-epoch instance for timing.
module tb_train_scheduler;
  localparam int DW = 112;
  localparam logic [DW-1:0] K = {16'h5A5A, 96'h0};
  logic clk, rst;
  logic load_we, load_done, load_done1, dp_ready, upd_done, wb_valid;
  logic [2:0] load_addr;
  logic [DW-1:0] load_data, wb_data;
  logic ram_en, ram_we, wt_valid, dp_valid, busy, train_done;
  logic [2:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata, dp_data;
  logic [7:0] epoch;
  logic ram_en1, ram_we1, wt_valid1, dp_valid1, busy1, train_done1;
  logic [2:0] ram_addr1;
  logic [DW-1:0] ram_wdata1, ram_rdata1, dp_data1, wd1;
  logic [7:0] epoch1;
  logic [DW-1:0] mem [8];
  logic [DW-1:0] mem1 [8];
  logic [DW-1:0] gold [8];
  logic [2:0] exp_rd [$];
  logic [DW:0] exp_row [$];
  logic [DW+2:0] exp_wr [$];
  logic [3:0] acc1 [$];
  int checks = 0, errors = 0;

  train_scheduler dut (
    .clk_i(clk), .rst_i(rst), .load_we_i(load_we), .load_addr_i(load_addr), .load_data_i(load_data),
    .load_done_i(load_done), .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata), .wt_valid_o(wt_valid), .dp_valid_o(dp_valid),
    .dp_data_o(dp_data), .dp_ready_i(dp_ready), .upd_done_i(upd_done), .wb_valid_i(wb_valid),
    .wb_data_i(wb_data), .epoch_o(epoch), .busy_o(busy), .train_done_o(train_done));

  train_scheduler #(.NUM_EPOCHS(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .load_we_i(load_we), .load_addr_i(load_addr), .load_data_i(load_data),
    .load_done_i(load_done1), .ram_en_o(ram_en1), .ram_we_o(ram_we1), .ram_addr_o(ram_addr1),
    .ram_wdata_o(ram_wdata1), .ram_rdata_i(ram_rdata1), .wt_valid_o(wt_valid1), .dp_valid_o(dp_valid1),
    .dp_data_o(dp_data1), .dp_ready_i(1'b1), .upd_done_i(1'b1), .wb_valid_i(1'b1),
    .wb_data_i(wb_data), .epoch_o(epoch1), .busy_o(busy1), .train_done_o(train_done1));

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
    if (ram_en1) begin
      if (ram_we1) mem1[ram_addr1] <= ram_wdata1;
      ram_rdata1 <= mem1[ram_addr1];
    end
  end

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  always @(negedge clk) begin
    if (busy && ram_en && !ram_we) begin
      chk("rd_expected", exp_rd.size() != 0, 1);
      if (exp_rd.size() != 0) chk("rd_addr", ram_addr, exp_rd.pop_front());
    end
    if ((dp_valid || wt_valid) && dp_ready) begin
      chk("row_expected", exp_row.size() != 0, 1);
      if (exp_row.size() != 0) chk("row_data", {wt_valid, dp_data}, exp_row.pop_front());
    end
    if (busy && ram_we) begin
      chk("wr_expected", exp_wr.size() != 0, 1);
      if (exp_wr.size() != 0) chk("wr_data", {ram_addr, ram_wdata}, exp_wr.pop_front());
    end
    if (busy1 && ram_en1) acc1.push_back({ram_we1, ram_addr1});
    if (busy1 && ram_we1) wd1 = ram_wdata1;
  end

  function automatic logic [DW-1:0] mkrow(int a);
    return {7{16'hA000 + 16'(a) * 16'h0111}};
  endfunction

  task automatic push_epoch(input logic [DW-1:0] w);
    exp_rd.push_back(3'd0);
    exp_row.push_back({1'b1, w});
    for (int i = 1; i <= 6; i++) begin
      exp_rd.push_back(3'(i));
      exp_row.push_back({1'b0, gold[i]});
    end
  endtask

  task automatic wait_valid;
    int n;
    for (n = 0; n < 60; n++) begin
      @(negedge clk);
      if (dp_valid || wt_valid) break;
    end
    chk("valid_timeout", n < 60, 1);
  endtask

  task automatic wait_epoch(input int e);
    int n;
    for (n = 0; n < 60; n++) begin
      @(negedge clk);
      if (epoch == 8'(e)) break;
    end
    chk("epoch_step", epoch, e);
  endtask

  task automatic pulse;
    @(posedge clk); #1 dp_ready = 1; upd_done = 1;
    @(posedge clk); #1 dp_ready = 0; upd_done = 0;
  endtask

  initial begin
    int n;
    rst = 1; load_we = 1; load_addr = 0; load_data = 0; load_done = 0; load_done1 = 0;
    dp_ready = 0; upd_done = 0; wb_valid = 0; wb_data = K;
    #12;
    chk("rst_ram_we", ram_we, 0);
    chk("rst_epoch", epoch, 0);
    chk("rst_dp_data", dp_data, 0);
    chk("rst_flags", {wt_valid, dp_valid, busy, train_done}, 4'b0);
    @(posedge clk); #1 rst = 0; load_we = 0;
    for (int a = 0; a < 7; a++) begin
      @(posedge clk); #1 load_we = 1; load_addr = 3'(a); load_data = mkrow(a); gold[a] = mkrow(a);
      #1 chk("load_we", ram_we, 1);
      chk("load_addr", ram_addr, a);
      chk("load_wdata", ram_wdata, mkrow(a));
      chk("load_busy", busy, 0);
    end
    @(posedge clk); #1 load_we = 0;

    load_done1 = 1;
    @(posedge clk); #1 load_done1 = 0;
    n = 0;
    while (!train_done1 && n < 40) begin
      @(posedge clk); #1 n++;
    end
    chk("done_latency", n, 28);
    chk("epoch_single", epoch1, 1);
    chk("acc_count", acc1.size(), 8);
    if (acc1.size() == 8) begin
      for (int i = 0; i < 7; i++) chk("acc_read", acc1[i], {1'b0, 3'(i)});
      chk("acc_write", acc1[7], 4'b1000);
    end
    chk("wb_single", wd1, K);

    push_epoch(gold[0]);
    load_done = 1;
    @(posedge clk); #1 load_done = 0;
    for (int k = 0; k < 7; k++) begin
      wait_valid;
      if (k == 3) begin
        for (int i = 0; i < 5; i++) begin
          chk("bp_valid", dp_valid, 1);
          chk("bp_data", dp_data, gold[3]);
          chk("bp_ram_en", ram_en, 0);
          @(negedge clk);
        end
      end
      if (k == 2) begin
        @(posedge clk); #1 dp_ready = 1; upd_done = 0;
        @(posedge clk); #1 dp_ready = 0;
        @(negedge clk) chk("late_idle1", ram_en, 0);
        @(posedge clk); #1;
        @(negedge clk) chk("late_idle2", ram_en, 0);
        @(posedge clk); #1 upd_done = 1;
        @(negedge clk) chk("late_idle3", ram_en, 0);
        @(posedge clk); #1 upd_done = 0;
        @(negedge clk) chk("late_next", ram_en, 0);
        @(posedge clk); #1;
        @(negedge clk) chk("late_read3", {ram_en, ram_addr}, 4'b1011);
      end else pulse;
    end
    exp_wr.push_back({3'd0, K + 1});
    push_epoch(K + 1);
    wb_valid = 1; wb_data = K + 1;
    wait_epoch(1);
    gold[0] = K + 1;
    for (int e = 2; e <= 4; e++) begin
      @(posedge clk); #1 dp_ready = 1; upd_done = 1; wb_data = K + 112'(e);
      exp_wr.push_back({3'd0, K + 112'(e)});
      if (e < 4) push_epoch(K + 112'(e));
      wait_epoch(e);
      gold[0] = K + 112'(e);
    end
    chk("done_flag", {train_done, busy, ram_en}, 3'b100);
    chk("queues_empty", exp_rd.size() + exp_row.size() + exp_wr.size(), 0);

    @(posedge clk); #1 dp_ready = 0; upd_done = 0; wb_valid = 0; rst = 1;
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i <= 4; i++) exp_rd.push_back(3'(i));
    exp_row.push_back({1'b1, gold[0]});
    for (int i = 1; i <= 3; i++) exp_row.push_back({1'b0, gold[i]});
    load_done = 1;
    @(posedge clk); #1 load_done = 0;
    for (int k = 0; k < 4; k++) begin
      wait_valid;
      pulse;
    end
    wait_valid;
    chk("pre_rst_data", {dp_valid, dp_data}, {1'b1, gold[4]});
    #2 rst = 1; load_done = 1;
    #1 chk("mid_rst_ram_we", ram_we, 0);
    chk("mid_rst_epoch", epoch, 0);
    chk("mid_rst_dp_data", dp_data, 0);
    chk("mid_rst_flags", {wt_valid, dp_valid, busy, train_done}, 4'b0);
    exp_rd.push_back(3'd0);
    @(posedge clk); #1 rst = 0;
    for (n = 0; n < 10; n++) begin
      @(negedge clk);
      if (busy && ram_en) break;
    end
    chk("post_rst_addr", {busy, ram_en, ram_addr}, 5'b11000);
    wait_valid;
    chk("post_rst_wt", {wt_valid, dp_data}, {1'b1, K + 112'd4});
    chk("final_queues", exp_rd.size() + exp_row.size() + exp_wr.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
